// File: rtl/fifo_flags_pkg.sv
// Shared FIFO definitions.
// Default word and address widths plus the count-width helper. The UART and
// Morse top levels reuse these so every FIFO instance agrees on its sizes.
// No ports; this file is a package only.
package fifo_flags_pkg;

    localparam int DEF_WORD_BITS = 8;
    localparam int DEF_ADDR_BITS = 4;

    // The count needs one bit more than the pointers so DEPTH itself fits.
    function automatic int count_bits(input int addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/fifo_flags_ram.sv
// fifo_ram: 2**ADDR_BITS x WORD_BITS simple dual-port storage.
// Ports:
//   clk_i    : clock, write port captures on its rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : asynchronous read data at raddr_i
// Contents are never reset; the owner tracks which entries are valid.
module fifo_ram
    import fifo_flags_pkg::*;
#(
    parameter int WORD_BITS = DEF_WORD_BITS,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [WORD_BITS-1:0] wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [WORD_BITS-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WORD_BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_flags.sv
// fifo_flags: first-word-fall-through FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, sticky overflow and
// underflow flags and a synchronous flush.
// Ports:
//   clk_i          : clock, all state on the rising edge
//   reset_i        : synchronous active-high reset (highest priority)
//   clear_i        : synchronous flush, empties FIFO and clears error flags
//   write_i/wdata_i: write request and data
//   read_i         : read request, pops the head entry
//   rdata_o        : head entry, valid while empty_o=0
//   empty_o/full_o : count == 0 / count == DEPTH
//   almost_empty_o : count <= AE_LEVEL
//   almost_full_o  : count >= AF_LEVEL
//   count_o        : stored entries, 0..DEPTH
//   overflow_o     : sticky, a write was rejected
//   underflow_o    : sticky, a read was rejected
module fifo_flags
    import fifo_flags_pkg::*;
#(
    parameter int WORD_BITS = DEF_WORD_BITS,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int AF_LEVEL  = (2 ** ADDR_BITS) - 2,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 write_i,
    input  logic [WORD_BITS-1:0] wdata_i,
    input  logic                 read_i,
    output logic [WORD_BITS-1:0] rdata_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 almost_empty_o,
    output logic                 almost_full_o,
    output logic [ADDR_BITS:0]   count_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam int CW    = count_bits(ADDR_BITS);
    localparam int DEPTH = 2 ** ADDR_BITS;

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

    logic [ADDR_BITS-1:0] wptr_q, wptr_d;
    logic [ADDR_BITS-1:0] rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 aempty_q, aempty_d;
    logic                 afull_q, afull_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic                 wr_acc;
    logic                 rd_acc;
    logic                 ram_we;

    // A write into a full FIFO is still fine if a pop frees a slot in the
    // same cycle; decisions use registered flags only.
    assign wr_acc = write_i & (~full_q | read_i);
    assign rd_acc = read_i & ~empty_q;

    // Reset and flush swallow any write in their cycle.
    assign ram_we = wr_acc & ~reset_i & ~clear_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        if (reset_i || clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + ADDR_BITS'(1);
            end
            if (rd_acc) begin
                rptr_d = rptr_q + ADDR_BITS'(1);
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CW'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CW'(1);
            end
            ovf_d = ovf_q | (write_i & ~wr_acc);
            unf_d = unf_q | (read_i & ~rd_acc);
        end

        // Flags come from the next count so they line up with count_o.
        empty_d  = (count_d == '0);
        full_d   = (count_d == DEPTH_CNT);
        aempty_d = (count_d <= AE_CNT);
        afull_d  = (count_d >= AF_CNT);
    end

    always_ff @(posedge clk_i) begin
        wptr_q   <= wptr_d;
        rptr_q   <= rptr_d;
        count_q  <= count_d;
        empty_q  <= empty_d;
        full_q   <= full_d;
        aempty_q <= aempty_d;
        afull_q  <= afull_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
    end

    fifo_ram #(
        .WORD_BITS (WORD_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (wptr_q),
        .wdata_i (wdata_i),
        .raddr_i (rptr_q),
        .rdata_o (rdata_o)
    );

    assign count_o        = count_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_empty_o = aempty_q;
    assign almost_full_o  = afull_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: tb/tb_fifo_flags.sv
// Scoreboard bench for fifo_flags with DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
// The driver pushes the expected post-edge state into a queue; the monitor
// pops one entry after every rising edge and compares all outputs.
module tb_fifo_flags;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       write_i = 1'b0;
    logic [7:0] wdata_i = 8'h00;
    logic       read_i = 1'b0;
    logic [7:0] rdata_o;
    logic       empty_o, full_o, almost_empty_o, almost_full_o;
    logic [2:0] count_o;
    logic       overflow_o, underflow_o;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        string      name;
        logic [2:0] cnt;
        bit         ovf;
        bit         unf;
        bit         chk_d;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] mdl[$];

    fifo_flags #(
        .WORD_BITS (8),
        .ADDR_BITS (2),
        .AF_LEVEL  (3),
        .AE_LEVEL  (1)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .clear_i        (clear_i),
        .write_i        (write_i),
        .wdata_i        (wdata_i),
        .read_i         (read_i),
        .rdata_o        (rdata_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .almost_empty_o (almost_empty_o),
        .almost_full_o  (almost_full_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string field, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s.%s actual=%0h required=%0h", name, field, act, expv);
    endtask

    // Monitor: compares the DUT against the oldest expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "count", int'(count_o), int'(e.cnt));
                chk(e.name, "empty", int'(empty_o), int'(e.cnt == 3'd0));
                chk(e.name, "full", int'(full_o), int'(e.cnt == 3'd4));
                chk(e.name, "aempty", int'(almost_empty_o), int'(e.cnt <= 3'd1));
                chk(e.name, "afull", int'(almost_full_o), int'(e.cnt >= 3'd3));
                chk(e.name, "ovf", int'(overflow_o), int'(e.ovf));
                chk(e.name, "unf", int'(underflow_o), int'(e.unf));
                if (e.chk_d) chk(e.name, "rdata", int'(rdata_o), int'(e.d));
            end
        end
    end

    // Drive one cycle of inputs and queue what the outputs must be after it.
    task automatic step(input string name, input bit w, input logic [7:0] wd, input bit r,
                        input bit clr, input bit rst, input logic [2:0] cnt,
                        input bit ovf, input bit unf, input bit chk_d, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        write_i = w;
        wdata_i = wd;
        read_i  = r;
        clear_i = clr;
        reset_i = rst;
        @(posedge clk);
        e.name = name; e.cnt = cnt; e.ovf = ovf; e.unf = unf; e.chk_d = chk_d; e.d = d;
        exp_q.push_back(e);
    endtask

    initial begin
        bit         rd;
        logic [7:0] head;
        int         guard;

        // 1. reset and idle
        step("reset",  0, 8'h00, 0, 0, 1, 3'd0, 0, 0, 0, 8'h00);
        step("idle",   0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 8'h00);

        // 2. fill to full
        step("wr_a1",  1, 8'hA1, 0, 0, 0, 3'd1, 0, 0, 1, 8'hA1);
        step("wr_b2",  1, 8'hB2, 0, 0, 0, 3'd2, 0, 0, 1, 8'hA1);
        step("wr_c3",  1, 8'hC3, 0, 0, 0, 3'd3, 0, 0, 1, 8'hA1);
        step("wr_d4",  1, 8'hD4, 0, 0, 0, 3'd4, 0, 0, 1, 8'hA1);

        // 3. overflow, sticky, then read+write while full
        step("ovf_wr", 1, 8'hEE, 0, 0, 0, 3'd4, 1, 0, 1, 8'hA1);
        step("ovf_st", 0, 8'h00, 0, 0, 0, 3'd4, 1, 0, 1, 8'hA1);
        step("full_rw",1, 8'hEE, 1, 0, 0, 3'd4, 1, 0, 1, 8'hB2);
        step("pop_b2", 0, 8'h00, 1, 0, 0, 3'd3, 1, 0, 1, 8'hC3);
        step("pop_c3", 0, 8'h00, 1, 0, 0, 3'd2, 1, 0, 1, 8'hD4);
        step("pop_d4", 0, 8'h00, 1, 0, 0, 3'd1, 1, 0, 1, 8'hEE);
        step("pop_ee", 0, 8'h00, 1, 0, 0, 3'd0, 1, 0, 0, 8'h00);

        // 4. underflow cases
        step("clr1",   0, 8'h00, 0, 1, 0, 3'd0, 0, 0, 0, 8'h00);
        step("empt_rw",1, 8'h55, 1, 0, 0, 3'd1, 0, 1, 1, 8'h55);
        step("pop_55", 0, 8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 8'h00);
        step("clr2",   0, 8'h00, 0, 1, 0, 3'd0, 0, 0, 0, 8'h00);
        step("empt_rd",0, 8'h00, 1, 0, 0, 3'd0, 0, 1, 0, 8'h00);
        step("clr3",   0, 8'h00, 0, 1, 0, 3'd0, 0, 0, 0, 8'h00);

        // 5. wrap-around, occupancy held at 2 or below
        for (int i = 0; i < 10; i++) begin
            rd = (mdl.size() >= 2);
            if (rd) void'(mdl.pop_front());
            mdl.push_back(8'h30 + 8'(i));
            head = mdl[0];
            step("wrap", 1, 8'h30 + 8'(i), rd, 0, 0, 3'(mdl.size()), 0, 0, 1, head);
        end
        while (mdl.size() > 0) begin
            void'(mdl.pop_front());
            head = (mdl.size() > 0) ? mdl[0] : 8'h00;
            step("drain", 0, 8'h00, 1, 0, 0, 3'(mdl.size()), 0, 0, mdl.size() > 0, head);
        end

        // 6. flush and reset with 3 entries and overflow set
        step("f_w61",  1, 8'h61, 0, 0, 0, 3'd1, 0, 0, 1, 8'h61);
        step("f_w62",  1, 8'h62, 0, 0, 0, 3'd2, 0, 0, 1, 8'h61);
        step("f_w63",  1, 8'h63, 0, 0, 0, 3'd3, 0, 0, 1, 8'h61);
        step("f_w64",  1, 8'h64, 0, 0, 0, 3'd4, 0, 0, 1, 8'h61);
        step("f_ovf",  1, 8'h65, 0, 0, 0, 3'd4, 1, 0, 1, 8'h61);
        step("f_pop",  0, 8'h00, 1, 0, 0, 3'd3, 1, 0, 1, 8'h62);
        step("clr_wr", 1, 8'h77, 0, 1, 0, 3'd0, 0, 0, 0, 8'h00);
        step("aft_clr",1, 8'h78, 0, 0, 0, 3'd1, 0, 0, 1, 8'h78);
        step("r_w79",  1, 8'h79, 0, 0, 0, 3'd2, 0, 0, 1, 8'h78);
        step("r_w7a",  1, 8'h7A, 0, 0, 0, 3'd3, 0, 0, 1, 8'h78);
        step("r_w7b",  1, 8'h7B, 0, 0, 0, 3'd4, 0, 0, 1, 8'h78);
        step("r_ovf",  1, 8'h7C, 0, 0, 0, 3'd4, 1, 0, 1, 8'h78);
        step("r_pop",  0, 8'h00, 1, 0, 0, 3'd3, 1, 0, 1, 8'h79);
        step("rst_wr", 1, 8'h7F, 0, 0, 1, 3'd0, 0, 0, 0, 8'h00);
        step("aft_rst",1, 8'h80, 0, 0, 0, 3'd1, 0, 0, 1, 8'h80);

        @(negedge clk);
        write_i = 0; read_i = 0; clear_i = 0; reset_i = 0;

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain_queue actual=%0d required=0 pending", exp_q.size());
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
